// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and parity helpers, common to TX and RX.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // Parity over a zero-extended payload; odd parity inverts the XOR.
  function automatic logic calc_parity(input logic [15:0] data, input logic ptype);
    return (^data) ^ (ptype == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with push/pop, full/empty flags and an occupancy count.
// Pushes while full and pops while empty are ignored.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  // Storage array; contents need no reset since the pointers define validity.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: input FIFO, prescaled bit timer, frame FSM and
// registered serial output. Frame settings are latched when a word is popped.
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int PRESCALE_W = 8
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic [DATA_WIDTH-1:0]         TX_IN_P,
  input  logic                          TX_IN_V,
  output logic                          TX_IN_R,
  input  logic [PRESCALE_W-1:0]         Prescale,
  input  logic                          parity_enable,
  input  logic                          parity_type,
  input  logic                          two_stop,
  output logic                          TX_OUT_S,
  output logic                          TX_OUT_V,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  logic [DATA_WIDTH-1:0] fifo_rdata;
  logic                  fifo_full, fifo_empty, fifo_pop;

  uart_state_e           state_q, state_d;
  logic [PRESCALE_W-1:0] timer_q, timer_d;
  logic [PRESCALE_W-1:0] presc_q, presc_d;
  logic [BW-1:0]         bit_idx_q, bit_idx_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic                  par_q, par_d;
  logic                  pe_q, pe_d;
  logic                  two_stop_q, two_stop_d;
  logic                  stop_idx_q, stop_idx_d;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;
  logic                  bit_end, start_frame;

  uart_sync_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (CLK),
    .rst_ni  (RST),
    .push_i  (TX_IN_V),
    .wdata_i (TX_IN_P),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign TX_IN_R  = ~fifo_full;
  assign TX_OUT_S = tx_q;
  assign TX_OUT_V = busy_q;
  assign bit_end  = (timer_q == presc_q - PRESCALE_W'(1));
  assign fifo_pop = start_frame;

  // Frame FSM, bit timer and shift register; a new frame starts from IDLE or
  // directly out of the last stop-bit cycle so back-to-back frames have no gap.
  always_comb begin
    state_d     = state_q;
    presc_d     = presc_q;
    bit_idx_d   = bit_idx_q;
    shreg_d     = shreg_q;
    par_d       = par_q;
    pe_d        = pe_q;
    two_stop_d  = two_stop_q;
    stop_idx_d  = stop_idx_q;
    start_frame = 1'b0;
    timer_d     = (state_q == ST_IDLE || bit_end) ? '0 : timer_q + PRESCALE_W'(1);

    case (state_q)
      ST_IDLE: start_frame = ~fifo_empty;
      ST_START: begin
        if (bit_end) begin
          state_d   = ST_DATA;
          bit_idx_d = '0;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          shreg_d = shreg_q >> 1;
          if (bit_idx_q == BW'(DATA_WIDTH-1)) begin
            state_d    = pe_q ? ST_PARITY : ST_STOP;
            stop_idx_d = 1'b0;
          end else begin
            bit_idx_d = bit_idx_q + BW'(1);
          end
        end
      end
      ST_PARITY: begin
        if (bit_end) begin
          state_d    = ST_STOP;
          stop_idx_d = 1'b0;
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          if (stop_idx_q == two_stop_q) begin
            if (!fifo_empty) start_frame = 1'b1;
            else             state_d     = ST_IDLE;
          end else begin
            stop_idx_d = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (start_frame) begin
      state_d    = ST_START;
      shreg_d    = fifo_rdata;
      presc_d    = (Prescale == '0) ? PRESCALE_W'(1) : Prescale;
      pe_d       = parity_enable;
      par_d      = calc_parity(16'(fifo_rdata), parity_type);
      two_stop_d = two_stop;
      bit_idx_d  = '0;
      stop_idx_d = 1'b0;
    end
  end

  // Line level and busy flag for the current state, registered one cycle later.
  always_comb begin
    tx_d   = 1'b1;
    busy_d = (state_q != ST_IDLE);
    case (state_q)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = shreg_q[0];
      ST_PARITY: tx_d = par_q;
      default:   tx_d = 1'b1;
    endcase
  end

  // State and output registers; reset forces an idle-high line immediately.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= ST_IDLE;
      timer_q    <= '0;
      presc_q    <= PRESCALE_W'(1);
      bit_idx_q  <= '0;
      shreg_q    <= '0;
      par_q      <= 1'b0;
      pe_q       <= 1'b0;
      two_stop_q <= 1'b0;
      stop_idx_q <= 1'b0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      presc_q    <= presc_d;
      bit_idx_q  <= bit_idx_d;
      shreg_q    <= shreg_d;
      par_q      <= par_d;
      pe_q       <= pe_d;
      two_stop_q <= two_stop_d;
      stop_idx_q <= stop_idx_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
    end
  end

endmodule
